// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parameter limits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    function automatic bit uart_params_legal(input int data_bits, input int oversample,
                                             input int stop_bits);
        return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
               (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
               (oversample % 2 == 0) &&
               (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-frame valid/ready handshake bundle
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receive engine with valid/ready frame delivery
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            s_tick,
    uart_rx_param_if.master m_rx,
    output logic            busy
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam uart_state_e       AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

    logic                 w_rx_s;
    logic                 w_frm_err;

    uart_state_e          r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frm_err;
    logic                 r_par_err;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Framing error including the stop sample taken on this tick
    assign w_frm_err = r_frm_err | ~w_rx_s;

    // Receive FSM on s_tick, plus the handshake that clears the held frame;
    // a completion is written after the clear so it wins a same-cycle accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_frm_err    <= 1'b0;
            r_par_err    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_rx_valid && m_rx.rx_ready) begin
                r_rx_valid   <= 1'b0;
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
                r_overrun    <= 1'b0;
            end
            if (s_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_tick_cnt <= '0;
                            r_state    <= START;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == TICK_MID) begin
                            if (w_rx_s) begin
                                r_state <= IDLE;
                            end else begin
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                                r_frm_err  <= 1'b0;
                                r_par_err  <= 1'b0;
                                r_state    <= DATA;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= AFTER_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_err  <= ((^r_shift) ^ w_rx_s) != 1'(PARITY_ODD);
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == STOP_LAST) begin
                                r_bit_cnt    <= '0;
                                r_state      <= IDLE;
                                r_rx_data    <= r_shift;
                                r_frame_err  <= w_frm_err;
                                r_parity_err <= r_par_err;
                                r_overrun    <= r_rx_valid & ~m_rx.rx_ready;
                                r_rx_valid   <= 1'b1;
                            end else begin
                                r_frm_err <= w_frm_err;
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign m_rx.rx_data    = r_rx_data;
    assign m_rx.rx_valid   = r_rx_valid;
    assign m_rx.frame_err  = r_frame_err;
    assign m_rx.parity_err = r_parity_err;
    assign m_rx.overrun    = r_overrun;
    assign busy            = (r_state != IDLE);
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine, the successor to the fixed 8N1 receiver.
- Runs entirely in the `clk` domain; `s_tick` is an oversampling clock enable from the baud generator.
- Configurable data width, parity and stop bits; includes an input synchroniser and false-start rejection.
- Reports framing, parity and overrun errors and delivers each frame over a valid/ready handshake to the APB UART register block.

Parameters:
DATA_BITS  8  data bits per frame, legal 5..9, LSB first
OVERSAMPLE  16  s_tick pulses per bit period, even, legal 8..32
PARITY_EN  0  1 = parity bit present after the data bits
PARITY_ODD  0  1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
STOP_BITS  1  number of stop bits, 1 or 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous, idles high
s_tick  input  1  oversampling enable, one clk cycle wide per tick
rx_data  output  DATA_BITS  received data word, valid while rx_valid=1
rx_valid  output  1  frame available; held until accepted
rx_ready  input  1  consumer accepts when rx_valid & rx_ready on a clk edge
frame_err  output  1  stop bit sampled 0 in the frame held in rx_data
parity_err  output  1  parity mismatch in the held frame (always 0 when PARITY_EN=0)
overrun  output  1  held frame overwrote an unaccepted earlier frame
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all counters 0; shift register 0; synchroniser flops 1; all outputs 0.
- rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s. rx_s lags the line by 2 clk.
- The FSM and counters update only on clk edges where s_tick=1, except for the handshake logic.
- Tick counter width is clog2(OVERSAMPLE); the bit counter counts to DATA_BITS-1.
- IDLE: on rx_s=0, tick_cnt=0 and go to START.
- START: at tick_cnt==OVERSAMPLE/2-1 (mid-bit):
  - rx_s=1: false start, return to IDLE with no output.
  - rx_s=0: tick_cnt=0, bit_cnt=0, go to DATA.
- DATA: at tick_cnt==OVERSAMPLE-1, sample rx_s into the MSB of the shift register (shift right) and reset tick_cnt.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else to STOP.
  - rx_data is right-aligned: the first received bit is bit 0.
- PARITY: at OVERSAMPLE-1, sample rx_s. parity_err_int = (^data ^ rx_s) != PARITY_ODD. Go to STOP.
- STOP: at OVERSAMPLE-1, sample rx_s; any 0 sets frame_err_int.
  - With STOP_BITS=2, both stop bits are sampled.
  - After the last stop sample, go directly to IDLE. This allows back-to-back frames; no waiting for the end of the stop bit.
- Completion, on the clk edge of the last stop sample:
  - rx_data <= shift register; frame_err/parity_err <= internal flags; rx_valid <= 1.
  - overrun <= rx_valid & ~rx_ready (old frame still unaccepted).
  - A frame with a framing error is still delivered, with its flag set.
- Handshake: rx_valid & rx_ready clears rx_valid, frame_err, parity_err and overrun on the next edge.
  - rx_data keeps its old value until the next completion.
  - If a completion coincides with acceptance in the same cycle, the completion wins: rx_valid stays 1, new data is loaded and overrun=0.
- Latency: rx_valid rises 1 clk after the s_tick edge of the final stop sample.
- Line held low: after a framing error the FSM re-enters START on the next tick. This repeats, one framing-error frame per frame time (no break detection in this block).
- s_tick stuck 0: the FSM freezes and no timeout is applied.
- Reset mid-frame: partial data is discarded and any pending rx_valid is lost.

Decomposition:
- Shared package uart_pkg: the state enum (IDLE, START, DATA, PARITY, STOP) and parameter-legality constants. The transmitter successor reuses them.
- One natural sub-module: sync_2ff (generic 2-flop synchroniser, reset value parameter = 1), shared with the GPIO inputs.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 with rx_ready=0: rx_data=0xA5, rx_valid=1, frame_err=0, parity_err=0, overrun=0. Pulse rx_ready: rx_valid=0 on the next clk.
- False start: rx low for 5 ticks, then high: rx_valid stays 0, busy returns to 0 by tick 8, and a following 0x3C is received correctly.
- PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7: 0x41 with parity 0 gives parity_err=0. 0x41 with parity 1 gives rx_data=0x41, parity_err=1.
- Stop bit driven 0 while sending 0x55: rx_valid=1, rx_data=0x55, frame_err=1. With STOP_BITS=2 and only the second stop bit 0: frame_err=1.
- Back-to-back 0x11, 0x22 with rx_ready=0: second completion gives rx_data=0x22, overrun=1. Repeat with rx_ready=1 exactly on the completion cycle: overrun=0.
- Assert rst_n=0 mid-DATA of 0xFF, release, then send 0x0F: outputs are 0 during reset, and only 0x0F is delivered, error-free.
